// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array sequencer.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sa_state_t;

    localparam int ACC_WIDTH = 32;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int sa_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sa_skew_gen.sv
// One lane of the operand feed skew: lane LANE injects k index t-LANE
// while LANE <= t < LANE+kl and the array is enabled.
module sa_skew_gen
    import sa_pkg::*;
#(
    parameter int LANE = 0,
    parameter int KW   = 3,
    parameter int TW   = 4
) (
    input  logic [TW-1:0] t,
    input  logic [KW-1:0] kl,
    input  logic          pe_en,
    output logic          valid,
    output logic [KW-1:0] idx
);

    localparam logic [TW:0] LANE_W = (TW+1)'(LANE);

    logic [TW:0] t_ext;
    logic [TW:0] hi_excl;
    logic [TW:0] diff;

    // One extra bit so LANE+kl cannot wrap for the last lane.
    assign t_ext   = {1'b0, t};
    assign hi_excl = LANE_W + (TW+1)'(kl);
    assign diff    = t_ext - LANE_W;

    assign valid = pe_en && (t_ext >= LANE_W) && (t_ext < hi_excl);
    assign idx   = valid ? diff[KW-1:0] : '0;

endmodule

// File: rtl/sa_ctrl.sv
// Sequencer for an M x K x N systolic array: clear, skewed operand feed, drain, done.
// Optional macro SA_CTRL_PERF_EN adds a saturating stall counter output perf_stall_cnt.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4,
    parameter int PE_LAT = 1,
    parameter int KW     = sa_width(K)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            src_ready,
    output logic            busy,
    output logic            pe_clear,
    output logic            pe_en,
    output logic [M-1:0]    a_valid,
    output logic [M*KW-1:0] a_idx,
    output logic [N-1:0]    b_valid,
    output logic [N*KW-1:0] b_idx,
    output logic            c_valid,
    output logic            done,
    output logic            err_klen
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [15:0]     perf_stall_cnt
`endif
);

    localparam int TW    = sa_width(K + M + N - 2 + PE_LAT);
    localparam int T_OFS = M + N - 3 + PE_LAT;
    localparam logic [KW-1:0] K_MAX = KW'(K);

    sa_state_t     state_reg;
    logic [TW-1:0] t_reg;
    logic [KW-1:0] kl_reg;
    logic [TW-1:0] t_last;

    // Last enabled RUN cycle is t == T-1 with T = kl + M + N - 2 + PE_LAT.
    assign t_last = TW'(kl_reg) + TW'(T_OFS);
    assign pe_en  = (state_reg == RUN) && src_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            t_reg     <= '0;
            kl_reg    <= '0;
            busy      <= 1'b0;
            pe_clear  <= 1'b0;
            c_valid   <= 1'b0;
            done      <= 1'b0;
            err_klen  <= 1'b0;
        end else begin
            pe_clear <= 1'b0;
            c_valid  <= 1'b0;
            done     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        kl_reg    <= (k_len > K_MAX) ? K_MAX : k_len;
                        if (k_len > K_MAX)
                            err_klen <= 1'b1;
                        state_reg <= CLEAR;
                        pe_clear  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    t_reg <= '0;
                    if (kl_reg == '0) begin
                        state_reg <= DONE;
                        c_valid   <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (src_ready) begin
                        t_reg <= t_reg + 1'b1;
                        if (t_reg == t_last) begin
                            state_reg <= DONE;
                            c_valid   <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_row
            sa_skew_gen #(.LANE(gi), .KW(KW), .TW(TW)) u_row (
                .t     (t_reg),
                .kl    (kl_reg),
                .pe_en (pe_en),
                .valid (a_valid[gi]),
                .idx   (a_idx[gi*KW +: KW])
            );
        end
        for (gi = 0; gi < N; gi++) begin : g_col
            sa_skew_gen #(.LANE(gi), .KW(KW), .TW(TW)) u_col (
                .t     (t_reg),
                .kl    (kl_reg),
                .pe_en (pe_en),
                .valid (b_valid[gi]),
                .idx   (b_idx[gi*KW +: KW])
            );
        end
    endgenerate

`ifdef SA_CTRL_PERF_EN
    // Counts stalled RUN cycles; value survives done until the next clear.
    always_ff @(posedge clk) begin
        if (reset || pe_clear)
            perf_stall_cnt <= '0;
        else if (state_reg == RUN && !src_ready && perf_stall_cnt != 16'hFFFF)
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// Self-checking bench for sa_ctrl: table of commands, per-cycle scoreboard, reset corner case.
module tb_sa_ctrl;
    localparam int M = 4, K = 4, N = 4, PE_LAT = 1, KW = 3;

    logic            clk = 1'b0;
    logic            reset, start, src_ready;
    logic [KW-1:0]   k_len;
    logic            busy, pe_clear, pe_en, c_valid, done, err_klen;
    logic [M-1:0]    a_valid;
    logic [M*KW-1:0] a_idx;
    logic [N-1:0]    b_valid;
    logic [N*KW-1:0] b_idx;

    sa_ctrl #(.M(M), .K(K), .N(N), .PE_LAT(PE_LAT), .KW(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .src_ready(src_ready),
        .busy(busy), .pe_clear(pe_clear), .pe_en(pe_en),
        .a_valid(a_valid), .a_idx(a_idx), .b_valid(b_valid), .b_idx(b_idx),
        .c_valid(c_valid), .done(done), .err_klen(err_klen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            busy;
        logic            pe_clear;
        logic            pe_en;
        logic [M-1:0]    av;
        logic [M*KW-1:0] ai;
        logic [N-1:0]    bv;
        logic [N*KW-1:0] bi;
        logic            c_valid;
        logic            done;
        logic            err;
    } obs_t;

    typedef struct {
        int kl;
        int stall_at;
        int stall_len;
        int restart_at;
        int exp_done;
    } vec_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic err_model = 1'b0;

    function automatic obs_t actual();
        obs_t o;
        o.busy = busy; o.pe_clear = pe_clear; o.pe_en = pe_en;
        o.av = a_valid; o.ai = a_idx; o.bv = b_valid; o.bi = b_idx;
        o.c_valid = c_valid; o.done = done; o.err = err_klen;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one command and compare every cycle against the reference model until done.
    task automatic run_vec(input int kl, input int stall_at, input int stall_len,
                           input int restart_at, output int done_cyc);
        int   kle;
        int   tt;
        int   mt;
        int   ph;
        obs_t e;
        kle = (kl > K) ? K : kl;
        tt  = kle + M + N - 2 + PE_LAT;
        mt  = 0;
        ph  = 1;
        done_cyc = -1;
        if (kl > K) err_model = 1'b1;
        start = 1'b1; k_len = KW'(kl); src_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            src_ready = !(c >= stall_at && c < stall_at + stall_len);
            start     = (c == restart_at);
            k_len     = 3'd7;
            e = '0;
            e.busy = 1'b1;
            e.err  = err_model;
            case (ph)
                1: begin
                    e.pe_clear = 1'b1;
                    ph = (kle == 0) ? 3 : 2;
                end
                2: begin
                    if (src_ready) begin
                        e.pe_en = 1'b1;
                        for (int i = 0; i < M; i++)
                            if (mt >= i && mt < i + kle) begin
                                e.av[i] = 1'b1;
                                e.ai[i*KW +: KW] = KW'(mt - i);
                            end
                        for (int j = 0; j < N; j++)
                            if (mt >= j && mt < j + kle) begin
                                e.bv[j] = 1'b1;
                                e.bi[j*KW +: KW] = KW'(mt - j);
                            end
                        if (mt == tt - 1) ph = 3;
                        mt++;
                    end
                end
                default: begin
                    e.c_valid = 1'b1;
                    e.done    = 1'b1;
                    done_cyc  = c;
                end
            endcase
            exp_q.push_back(e);
            @(negedge clk);
            check($sformatf("k%0d_cyc%0d", kl, c), 64'(actual()), 64'(exp_q.pop_front()));
            @(posedge clk); #1;
        end
        start = 1'b0; src_ready = 1'b1;
        e = '0;
        e.err = err_model;
        exp_q.push_back(e);
        @(negedge clk);
        check($sformatf("k%0d_idle", kl), 64'(actual()), 64'(exp_q.pop_front()));
        @(posedge clk); #1;
    endtask

    vec_t vecs[8];
    int   dc;

    initial begin
        vecs[0] = '{4, 0, 0, 0, 13};   // nominal
        vecs[1] = '{2, 0, 0, 0, 11};   // short reduction
        vecs[2] = '{0, 0, 0, 0, 2};    // empty reduction
        vecs[3] = '{4, 4, 3, 0, 16};   // three-cycle stall early in RUN
        vecs[4] = '{4, 0, 0, 5, 13};   // start while busy is ignored
        vecs[5] = '{3, 0, 0, 12, 12};  // start in DONE cycle is ignored
        vecs[6] = '{1, 9, 2, 0, 12};   // stall on the final RUN cycle
        vecs[7] = '{7, 0, 0, 0, 13};   // oversize k_len clamps and flags

        reset = 1'b1; start = 1'b0; k_len = '0; src_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_state", 64'(actual()), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_vec(vecs[v].kl, vecs[v].stall_at, vecs[v].stall_len, vecs[v].restart_at, dc);
            check($sformatf("done_cycle_v%0d", v), 64'(dc), 64'(vecs[v].exp_done));
        end

        // Reset mid-run: no done pulse, everything (including sticky err) clears.
        start = 1'b1; k_len = 3'd4; src_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) reset = 1'b1;
            @(negedge clk);
            check($sformatf("abort_cyc%0d", c), 64'({busy, done, c_valid}), 64'(3'b100));
            @(posedge clk); #1;
        end
        reset = 1'b0;
        err_model = 1'b0;
        @(negedge clk);
        check("abort_cleared", 64'(actual()), 64'(0));
        @(posedge clk); #1;

        run_vec(4, 0, 0, 0, dc);
        check("done_cycle_after_reset", 64'(dc), 64'(13));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
